// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: digit patterns (active-high gfedcba), bus polarity
// and the countdown monitor state type.
package seven_seg_pkg;

    // Display bus is driven active-low by bomb_controller.
    localparam bit ACTIVE_LOW = 1'b1;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic logic [6:0] to_active_high(input logic [6:0] pin);
        return ACTIVE_LOW ? ~pin : pin;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational seven-segment decoder: active-high gfedcba pattern to {legal, blank, digit}.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       legal_o,
    output logic       blank_o,
    output logic [3:0] digit_o
);

    always_comb begin
        legal_o = 1'b1;
        blank_o = 1'b0;
        digit_o = 4'h0;
        case (seg_i)
            SEG_BLANK: blank_o = 1'b1;
            SEG_0:     digit_o = 4'h0;
            SEG_1:     digit_o = 4'h1;
            SEG_2:     digit_o = 4'h2;
            SEG_3:     digit_o = 4'h3;
            SEG_4:     digit_o = 4'h4;
            SEG_5:     digit_o = 4'h5;
            SEG_6:     digit_o = 4'h6;
            SEG_7:     digit_o = 4'h7;
            SEG_8:     digit_o = 4'h8;
            SEG_9:     digit_o = 4'h9;
            SEG_A:     digit_o = 4'hA;
            SEG_B:     digit_o = 4'hB;
            SEG_C:     digit_o = 4'hC;
            SEG_D:     digit_o = 4'hD;
            SEG_E:     digit_o = 4'hE;
            SEG_F:     digit_o = 4'hF;
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_monitor.sv
// Receive-side checker for the seven-segment display bus: glitch filter, decode, and
// strict-countdown verification with sticky error flags.
module seven_seg_monitor
    import seven_seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       async_nreset,
    input  logic [7:0] hex_input,
    input  logic       clear,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       dp,
    output logic       digit_strobe,
    output logic       done,
    output logic       step_error,
    output logic       invalid_pattern,
    output logic       timeout
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0]    PIN_BLANK  = {ACTIVE_LOW, SEG_BLANK ^ {7{ACTIVE_LOW}}};

    logic [7:0]    in_q, in_d, acc_q, acc_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [TW-1:0] tmo_q, tmo_d;
    state_e        state_q, state_d;
    logic [3:0]    prev_q, prev_d, digit_q, digit_d;
    logic          valid_q, valid_d, dp_q, dp_d, strobe_q, strobe_d;
    logic          done_q, done_d, step_q, step_d, inv_q, inv_d, tmo_flag_q, tmo_flag_d;
    logic          accept, dec_legal, dec_blank;
    logic [3:0]    dec_digit;

    seven_seg_decode u_decode (
        .seg_i   (to_active_high(in_q[6:0])),
        .legal_o (dec_legal),
        .blank_o (dec_blank),
        .digit_o (dec_digit)
    );

    // A new sample equal to in_q is one more unchanged edge; acceptance happens on the
    // edge that brings the count to STABLE_CYCLES, when hex_input == in_q.
    always_comb begin
        in_d = hex_input;
        if (hex_input != in_q) begin
            stab_d = '0;
        end else if (stab_q == STABLE_MAX) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + 1'b1;
        end
        accept = (stab_d == STABLE_MAX) && (in_q != acc_q);
    end

    always_comb begin
        acc_d      = acc_q;
        tmo_d      = tmo_q;
        state_d    = state_q;
        prev_d     = prev_q;
        digit_d    = digit_q;
        valid_d    = valid_q;
        dp_d       = dp_q;
        strobe_d   = 1'b0;
        done_d     = done_q;
        step_d     = step_q;
        inv_d      = inv_q;
        tmo_flag_d = tmo_flag_q;

        // Recording the pattern even under clear keeps it from being accepted again later.
        if (accept) begin
            acc_d = in_q;
        end

        if (clear) begin
            state_d    = StIdle;
            done_d     = 1'b0;
            step_d     = 1'b0;
            inv_d      = 1'b0;
            tmo_d      = '0;
            tmo_flag_d = 1'b0;
        end else if (accept) begin
            dp_d  = in_q[7] ^ ACTIVE_LOW;
            tmo_d = '0;
            if (!dec_legal) begin
                inv_d   = 1'b1;
                valid_d = 1'b0;
            end else if (dec_blank) begin
                valid_d = 1'b0;
                if (state_q != StIdle) begin
                    state_d = StIdle;
                    done_d  = 1'b0;
                end
            end else begin
                digit_d  = dec_digit;
                valid_d  = 1'b1;
                strobe_d = 1'b1;
                prev_d   = dec_digit;
                case (state_q)
                    StIdle: begin
                        state_d = (dec_digit == 4'h0) ? StDone : StRun;
                        done_d  = (dec_digit == 4'h0);
                    end
                    StRun: begin
                        if (dec_digit != prev_q - 4'h1) begin
                            step_d = 1'b1;
                        end
                        if (dec_digit == 4'h0) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end
                    end
                    StDone:  step_d = 1'b1;
                    default: state_d = StIdle;
                endcase
            end
        end else if (state_q == StRun) begin
            if (tmo_q != TMO_MAX) begin
                tmo_d = tmo_q + 1'b1;
            end
            if (tmo_d == TMO_MAX) begin
                tmo_flag_d = 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            in_q       <= PIN_BLANK;
            acc_q      <= PIN_BLANK;
            stab_q     <= '0;
            tmo_q      <= '0;
            state_q    <= StIdle;
            prev_q     <= 4'h0;
            digit_q    <= 4'h0;
            valid_q    <= 1'b0;
            dp_q       <= 1'b0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            step_q     <= 1'b0;
            inv_q      <= 1'b0;
            tmo_flag_q <= 1'b0;
        end else begin
            in_q       <= in_d;
            acc_q      <= acc_d;
            stab_q     <= stab_d;
            tmo_q      <= tmo_d;
            state_q    <= state_d;
            prev_q     <= prev_d;
            digit_q    <= digit_d;
            valid_q    <= valid_d;
            dp_q       <= dp_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
            step_q     <= step_d;
            inv_q      <= inv_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign digit           = digit_q;
    assign digit_valid     = valid_q;
    assign dp              = dp_q;
    assign digit_strobe    = strobe_q;
    assign done            = done_q;
    assign step_error      = step_q;
    assign invalid_pattern = inv_q;
    assign timeout         = tmo_flag_q;

endmodule
